// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: tag layout, instruction classes and CDB tag matching.
package tomasulo_pkg;

    typedef logic [7:0] tag_t;

    localparam int TAG_VALID = 7;
    localparam int TAG_MEM   = 6;
    localparam int TAG_ADD   = 5;
    localparam int TAG_MUL   = 4;
    localparam int CDB_LANES = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_MEM = 2'd2,
        OP_RSV = 2'd3
    } op_e;

    function automatic logic tag_match(input tag_t a, input tag_t b);
        return a[TAG_VALID] && b[TAG_VALID] && (a == b);
    endfunction

    // Lane 0 sits in the most significant slice; the lowest matching lane wins.
    function automatic void cdb_lookup(
        input  tag_t                      t,
        input  logic [8*CDB_LANES-1:0]    tags,
        input  logic [32*CDB_LANES-1:0]   data,
        output logic                      hit,
        output logic [31:0]               val
    );
        hit = 1'b0;
        val = '0;
        for (int unsigned l = 0; l < CDB_LANES; l++) begin
            if (!hit && tag_match(tags[8*(CDB_LANES-1-l) +: 8], t)) begin
                hit = 1'b1;
                val = data[32*(CDB_LANES-1-l) +: 32];
            end
        end
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Instruction buffer for the dispatcher; pointers carry an extra wrap bit for full/empty.
module dispatch_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// In-order issue stage: buffers decoded instructions, reads/renames operands via the
// regfile + tag alias table, and retires tags from the 3-lane CDB.
module instruction_dispatcher
    import tomasulo_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    parameter  int NUM_REGS   = 16,
    localparam int RW         = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [1:0]              instr_op,
    input  logic [RW-1:0]           instr_rd,
    input  logic [RW-1:0]           instr_rs1,
    input  logic [RW-1:0]           instr_rs2,
    input  logic                    add_ready,
    input  logic                    mul_ready,
    input  logic                    mem_ready,
    input  logic [7:0]              add_tag,
    input  logic [7:0]              mul_tag,
    input  logic [7:0]              mem_tag,
    output logic                    add_issue,
    output logic                    mul_issue,
    output logic                    mem_issue,
    output logic [31:0]             src_out_1,
    output logic [31:0]             src_out_2,
    output logic                    src_out1_type,
    output logic                    src_out2_type,
    input  logic [32*CDB_LANES-1:0] CDB_data_serialized,
    input  logic [8*CDB_LANES-1:0]  CDB_tag_serialized,
    input  logic [RW-1:0]           dbg_addr,
    output logic [31:0]             dbg_data,
    output logic                    dbg_busy
);
    localparam int EW = 2 + 3*RW;

    logic [31:0]   reg_val [NUM_REGS];
    tag_t          reg_tag [NUM_REGS];

    logic [EW-1:0] fifo_din;
    logic [EW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [1:0]    head_op_bits;
    op_e           head_op;
    logic [RW-1:0] head_rd;
    logic [RW-1:0] head_rs1;
    logic [RW-1:0] head_rs2;
    logic          head_valid;
    logic          rename;
    tag_t          issue_tag;

    logic [NUM_REGS-1:0] retire_hit;
    logic [31:0]         retire_val [NUM_REGS];
    logic                fwd1_hit;
    logic                fwd2_hit;
    logic [31:0]         fwd1_val;
    logic [31:0]         fwd2_val;

    assign fifo_din = {instr_op, instr_rd, instr_rs1, instr_rs2};
    assign push     = en && instr_valid && !fifo_full;

    dispatch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_ready = !fifo_full;
    assign {head_op_bits, head_rd, head_rs1, head_rs2} = fifo_dout;
    assign head_op    = op_e'(head_op_bits);
    assign head_valid = en && !fifo_empty;

    assign add_issue = head_valid && (head_op == OP_ADD) && add_ready;
    assign mul_issue = head_valid && (head_op == OP_MUL) && mul_ready;
    assign mem_issue = head_valid && (head_op == OP_MEM) && mem_ready;
    assign rename    = add_issue || mul_issue || mem_issue;
    assign issue_tag = add_issue ? add_tag : (mul_issue ? mul_tag : mem_tag);
    // Reserved ops leave the buffer without touching any RS or register.
    assign pop       = rename || (head_valid && (head_op == OP_RSV));

    always_comb begin
        retire_hit = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            retire_val[r] = '0;
            cdb_lookup(reg_tag[r], CDB_tag_serialized, CDB_data_serialized,
                       retire_hit[r], retire_val[r]);
        end
    end

    // Operands see the pre-rename state; a same-cycle CDB hit is forwarded since the RS
    // does not snoop the CDB in its accept cycle.
    always_comb begin
        fwd1_hit      = 1'b0;
        fwd2_hit      = 1'b0;
        fwd1_val      = '0;
        fwd2_val      = '0;
        src_out_1     = '0;
        src_out_2     = '0;
        src_out1_type = 1'b0;
        src_out2_type = 1'b0;
        cdb_lookup(reg_tag[head_rs1], CDB_tag_serialized, CDB_data_serialized, fwd1_hit, fwd1_val);
        cdb_lookup(reg_tag[head_rs2], CDB_tag_serialized, CDB_data_serialized, fwd2_hit, fwd2_val);
        if (!fifo_empty) begin
            if (!reg_tag[head_rs1][TAG_VALID]) begin
                src_out_1 = reg_val[head_rs1];
            end else if (fwd1_hit) begin
                src_out_1 = fwd1_val;
            end else begin
                src_out_1     = {24'h0, reg_tag[head_rs1]};
                src_out1_type = 1'b1;
            end
            if (!reg_tag[head_rs2][TAG_VALID]) begin
                src_out_2 = reg_val[head_rs2];
            end else if (fwd2_hit) begin
                src_out_2 = fwd2_val;
            end else begin
                src_out_2     = {24'h0, reg_tag[head_rs2]};
                src_out2_type = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                reg_val[r] <= '0;
                reg_tag[r] <= '0;
            end
        end else if (en) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                // A rename overrides a same-cycle retire of the old tag, dropping its value.
                if (rename && (head_rd == RW'(r))) begin
                    reg_tag[r] <= issue_tag;
                end else if (retire_hit[r]) begin
                    reg_val[r] <= retire_val[r];
                    reg_tag[r] <= '0;
                end
            end
        end
    end

    assign dbg_data = reg_val[dbg_addr];
    assign dbg_busy = reg_tag[dbg_addr][TAG_VALID];

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher with a queue/array reference model checked every cycle.
module tb_instruction_dispatcher;

    localparam int DEPTH = 8;
    localparam int NREG  = 16;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } ins_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  instr_op = '0;
    logic [3:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic        add_ready = 1'b0, mul_ready = 1'b0, mem_ready = 1'b0;
    logic [7:0]  add_tag = '0, mul_tag = '0, mem_tag = '0;
    logic        add_issue, mul_issue, mem_issue;
    logic [31:0] src_out_1, src_out_2;
    logic        src_out1_type, src_out2_type;
    logic [95:0] cdb_data = '0;
    logic [23:0] cdb_tag = '0;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        dbg_busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instruction_dispatcher #(.FIFO_DEPTH(DEPTH), .NUM_REGS(NREG)) dut (
        .clk(clk), .reset(reset), .en(en),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .add_ready(add_ready), .mul_ready(mul_ready), .mem_ready(mem_ready),
        .add_tag(add_tag), .mul_tag(mul_tag), .mem_tag(mem_tag),
        .add_issue(add_issue), .mul_issue(mul_issue), .mem_issue(mem_issue),
        .src_out_1(src_out_1), .src_out_2(src_out_2),
        .src_out1_type(src_out1_type), .src_out2_type(src_out2_type),
        .CDB_data_serialized(cdb_data), .CDB_tag_serialized(cdb_tag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2);
        instr_valid = 1'b1;
        instr_op = op;
        instr_rd = rd;
        instr_rs1 = rs1;
        instr_rs2 = rs2;
    endtask

    task automatic cdb_set(input int lane, input logic [7:0] t, input logic [31:0] d);
        cdb_tag = '0;
        cdb_data = '0;
        cdb_tag[23-8*lane -: 8] = t;
        cdb_data[95-32*lane -: 32] = d;
    endtask

    // ---------------- reference model ----------------
    ins_t        q[$];
    ins_t        nq[$];
    logic [31:0] mval [NREG];
    logic [7:0]  mtag [NREG];
    logic [31:0] nval [NREG];
    logic [7:0]  ntag [NREG];

    // Busy source: forwarded from the first CDB lane carrying its tag, else the tag itself.
    function automatic void mread(input int r, input logic [23:0] ct, input logic [95:0] cd,
                                  output logic [31:0] d, output logic ty);
        d = mval[r];
        ty = 1'b0;
        if (mtag[r][7]) begin
            d = {24'h0, mtag[r]};
            ty = 1'b1;
            for (int l = 2; l >= 0; l--) begin
                if (ct[23-8*l -: 8] == mtag[r]) begin
                    d = cd[95-32*l -: 32];
                    ty = 1'b0;
                end
            end
        end
    endfunction

    initial begin
        ins_t h;
        logic e_add, e_mul, e_mem, have;
        logic [31:0] d;
        logic ty;
        logic [7:0] lt;
        forever begin
            @(negedge clk);
            h = '0;
            if (reset) begin
                nq.delete();
                for (int r = 0; r < NREG; r++) begin
                    nval[r] = '0;
                    ntag[r] = '0;
                end
            end else begin
                have = en && (q.size() > 0);
                if (have) h = q[0];
                e_add = have && (h.op == 2'd0) && add_ready;
                e_mul = have && (h.op == 2'd1) && mul_ready;
                e_mem = have && (h.op == 2'd2) && mem_ready;
                check("m_instr_ready", instr_ready, q.size() < DEPTH);
                check("m_add_issue", add_issue, e_add);
                check("m_mul_issue", mul_issue, e_mul);
                check("m_mem_issue", mem_issue, e_mem);
                if (e_add || e_mul || e_mem) begin
                    mread(h.rs1, cdb_tag, cdb_data, d, ty);
                    check("m_src1", src_out_1, d);
                    check("m_src1_type", src_out1_type, ty);
                    mread(h.rs2, cdb_tag, cdb_data, d, ty);
                    check("m_src2", src_out_2, d);
                    check("m_src2_type", src_out2_type, ty);
                end
                check("m_dbg_data", dbg_data, mval[dbg_addr]);
                check("m_dbg_busy", dbg_busy, mtag[dbg_addr][7]);

                nq = q;
                nval = mval;
                ntag = mtag;
                if (en) begin
                    for (int r = 0; r < NREG; r++) begin
                        if (mtag[r][7]) begin
                            for (int l = 2; l >= 0; l--) begin
                                lt = cdb_tag[23-8*l -: 8];
                                if (lt == mtag[r]) begin
                                    nval[r] = cdb_data[95-32*l -: 32];
                                    ntag[r] = '0;
                                end
                            end
                        end
                    end
                    if (have && (h.op == 2'd3 || e_add || e_mul || e_mem)) begin
                        void'(nq.pop_front());
                        if (e_add || e_mul || e_mem) begin
                            ntag[h.rd] = e_add ? add_tag : (e_mul ? mul_tag : mem_tag);
                            nval[h.rd] = mval[h.rd];
                        end
                    end
                    if (instr_valid && q.size() < DEPTH)
                        nq.push_back(ins_t'({instr_op, instr_rd, instr_rs1, instr_rs2}));
                end
            end
            @(posedge clk);
            q = nq;
            mval = nval;
            mtag = ntag;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        tick();
        tick();
        reset = 1'b0;
        dbg_addr = 4'd3;
        #3;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_add_issue", add_issue, 0);
        check("rst_src1", src_out_1, 0);
        check("rst_src2", src_out_2, 0);
        check("rst_dbg_busy", dbg_busy, 0);

        // 1: add r3 = r1 + r2
        tick();
        enq(2'd0, 4'd3, 4'd1, 4'd2);
        add_ready = 1'b1;
        add_tag = 8'hA0;
        #3 check("t1_no_issue_enq_cycle", add_issue, 0);
        tick();
        instr_valid = 1'b0;
        #3;
        check("t1_add_issue", add_issue, 1);
        check("t1_src1", src_out_1, 32'h0);
        check("t1_src1_type", src_out1_type, 0);
        check("t1_src2_type", src_out2_type, 0);
        tick();
        check("t1_r3_busy", dbg_busy, 1);

        // 2: mul r4 = r3 + r1, then CDB lane1 retires A0
        enq(2'd1, 4'd4, 4'd3, 4'd1);
        mul_ready = 1'b1;
        mul_tag = 8'h90;
        tick();
        instr_valid = 1'b0;
        #3;
        check("t2_mul_issue", mul_issue, 1);
        check("t2_src1_tag", src_out_1, 32'h0000_00A0);
        check("t2_src1_type", src_out1_type, 1);
        tick();
        mul_ready = 1'b0;
        cdb_set(1, 8'hA0, 32'd7);
        tick();
        cdb_set(0, 8'h00, 32'd0);
        dbg_addr = 4'd3;
        #1 check("t2_r3_val", dbg_data, 32'd7);
        check("t2_r3_busy", dbg_busy, 0);
        dbg_addr = 4'd4;
        #1 check("t2_r4_busy", dbg_busy, 1);

        // 3: r3 renamed to A0, then r5 = r3 + r3 issues while lane2 carries A0/5
        tick();
        enq(2'd0, 4'd3, 4'd0, 4'd0);
        tick();
        enq(2'd0, 4'd5, 4'd3, 4'd3);
        tick();
        instr_valid = 1'b0;
        add_tag = 8'hA1;
        cdb_set(2, 8'hA0, 32'd5);
        #3;
        check("t3_add_issue", add_issue, 1);
        check("t3_src1", src_out_1, 32'd5);
        check("t3_src1_type", src_out1_type, 0);
        check("t3_src2", src_out_2, 32'd5);
        check("t3_src2_type", src_out2_type, 0);
        tick();
        cdb_set(0, 8'h00, 32'd0);
        dbg_addr = 4'd3;
        #1 check("t3_r3_val", dbg_data, 32'd5);
        dbg_addr = 4'd5;
        #1 check("t3_r5_busy", dbg_busy, 1);

        // 4: add stalls with mul behind it (mul RS ready but must not bypass)
        tick();
        add_ready = 1'b0;
        enq(2'd0, 4'd6, 4'd1, 4'd2);
        tick();
        enq(2'd1, 4'd7, 4'd1, 4'd2);
        tick();
        instr_valid = 1'b0;
        mul_ready = 1'b1;
        mul_tag = 8'h91;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("t4_stall_add", add_issue, 0);
            check("t4_stall_mul", mul_issue, 0);
            tick();
        end
        add_ready = 1'b1;
        add_tag = 8'hA2;
        #3;
        check("t4_add_first", add_issue, 1);
        check("t4_mul_waits", mul_issue, 0);
        tick();
        #3 check("t4_mul_second", mul_issue, 1);
        tick();
        add_ready = 1'b0;
        mul_ready = 1'b0;

        // en=0: nothing enqueued or issued
        en = 1'b0;
        add_ready = 1'b1;
        enq(2'd0, 4'd2, 4'd0, 4'd0);
        tick();
        tick();
        instr_valid = 1'b0;
        en = 1'b1;
        dbg_addr = 4'd2;
        #3;
        check("en0_nothing_queued", add_issue, 0);
        check("en0_r2_idle", dbg_busy, 0);

        // reserved op: popped with no issue and no rename
        mul_ready = 1'b1;
        mem_ready = 1'b1;
        enq(2'd3, 4'd1, 4'd2, 4'd3);
        tick();
        instr_valid = 1'b0;
        #3;
        check("rsv_no_add", add_issue, 0);
        check("rsv_no_mem", mem_issue, 0);
        tick();
        dbg_addr = 4'd1;
        #1 check("rsv_r1_idle", dbg_busy, 0);
        add_ready = 1'b0;
        mul_ready = 1'b0;
        mem_ready = 1'b0;

        // 5: fill to 8, 9th refused, drain
        for (int i = 0; i < 9; i++) begin
            enq(2'd2, 4'(8 + i % 8), 4'(i % 8), 4'd0);
            #3 check("t5_ready_during_fill", instr_ready, (i < 8) ? 1 : 0);
            tick();
        end
        instr_valid = 1'b0;
        #3 check("t5_full", instr_ready, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_tag = 8'hC0 | 8'(i);
            #1 check("t5_drain_issue", mem_issue, 1);
            tick();
        end
        #1;
        check("t5_drained", mem_issue, 0);
        check("t5_ready_again", instr_ready, 1);
        mem_ready = 1'b0;

        // 6: rename r3 to A1 in the same cycle the CDB retires its old tag A0
        add_ready = 1'b1;
        add_tag = 8'hA0;
        enq(2'd0, 4'd3, 4'd0, 4'd0);
        tick();
        tick();
        instr_valid = 1'b0;
        add_tag = 8'hA1;
        cdb_set(0, 8'hA0, 32'd99);
        #3 check("t6_add_issue", add_issue, 1);
        tick();
        cdb_set(0, 8'h00, 32'd0);
        add_ready = 1'b0;
        dbg_addr = 4'd3;
        #1;
        check("t6_r3_val_kept", dbg_data, 32'd5);
        check("t6_r3_busy", dbg_busy, 1);
        mul_ready = 1'b1;
        mul_tag = 8'h92;
        enq(2'd1, 4'd9, 4'd3, 4'd0);
        tick();
        instr_valid = 1'b0;
        #3;
        check("t6_src1_newtag", src_out_1, 32'h0000_00A1);
        check("t6_src1_type", src_out1_type, 1);
        tick();
        mul_ready = 1'b0;

        // reset mid-stream
        enq(2'd0, 4'd10, 4'd3, 4'd4);
        tick();
        enq(2'd2, 4'd11, 4'd3, 4'd4);
        tick();
        instr_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        add_ready = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst2_instr_ready", instr_ready, 1);
        check("rst2_no_add", add_issue, 0);
        check("rst2_no_mem", mem_issue, 0);
        for (int r = 0; r < NREG; r++) begin
            dbg_addr = 4'(r);
            #0.5 check("rst2_dbg_busy", dbg_busy, 0);
        end
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
